// File: rtl/ysyx_ifu_l1i.sv
// Instruction fetch unit with a set-associative L1 I-cache refilled over a single-beat read bus.
// Latency: hit -> valid_o 2 cycles after accept; miss -> valid_o 1 cycle after the last refill beat.
// Backpressure: ready_o only in IDLE; the result is held in VALID until next_ready is seen.
module ysyx_ifu_l1i #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              ready_o,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] ifu_araddr_o,
  output logic              ifu_arvalid_o,
  input  logic [DATA_W-1:0] ifu_rdata,
  input  logic              ifu_rvalid,
  input  logic              flush_i
);
  localparam int WO_W    = $clog2(LINE_WORDS);
  localparam int CNT_W   = (WO_W > 0) ? WO_W : 1;
  localparam int IDX_W   = $clog2(SETS);
  localparam int IDX_LSB = 2 + WO_W;
  localparam int TAG_W   = ADDR_W - IDX_LSB - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_VALID} state_t;
  state_t r_state, w_state_nxt;

  // Storage: data/tag arrays are never reset, only the valid and LRU bits are.
  logic [DATA_W-1:0] r_data  [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [SETS-1:0]   r_valid [WAYS];
  logic [SETS-1:0]   r_lru;            // way most recently used in each set
  logic [DATA_W-1:0] r_buf   [LINE_WORDS];
  logic [CNT_W-1:0]  r_cnt;            // refill beat number
  logic              r_vway;           // way chosen for the line being refilled
  logic              r_noinst;         // a flush hit this refill: deliver but do not install

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [CNT_W-1:0]  w_off;
  logic [ADDR_W-1:0] w_base;
  logic              w_hit, w_hit_way, w_victim;
  logic              w_beat, w_last, w_install;
  logic [DATA_W-1:0] w_hit_word;

  // All lookups and refills work on the latched request address.
  assign w_idx  = pc_o[IDX_LSB +: IDX_W];
  assign w_tag  = pc_o[ADDR_W-1 -: TAG_W];
  assign w_off  = CNT_W'((pc_o >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign w_base = pc_o & ~ADDR_W'(LINE_WORDS * 4 - 1);

  assign ready_o       = (r_state == S_IDLE);
  assign valid_o       = (r_state == S_VALID);
  assign ifu_arvalid_o = (r_state == S_FILL);
  assign ifu_araddr_o  = w_base | (ADDR_W'(r_cnt) << 2);

  assign w_beat    = (r_state == S_FILL) && ifu_rvalid;
  assign w_last    = w_beat && (r_cnt == CNT_W'(LINE_WORDS - 1));
  assign w_install = w_last && !r_noinst && !flush_i;

  // Tag compare across all ways; a flush in the same cycle forces a miss.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag) && !flush_i) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
      end
    end
  end

  assign w_hit_word = r_data[w_hit_way][w_idx][w_off];

  // Victim: lowest-numbered invalid way, otherwise the way not used most recently.
  always_comb begin
    w_victim = (WAYS == 2) ? ~r_lru[w_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_victim = 1'(w);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (prev_valid) w_state_nxt = S_LOOKUP;
      S_LOOKUP: w_state_nxt = w_hit ? S_VALID : S_FILL;
      S_FILL:   if (w_last) w_state_nxt = S_VALID;
      S_VALID:  if (next_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, delivered instruction and refill bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_o     <= '0;
      inst_o   <= '0;
      r_cnt    <= '0;
      r_vway   <= 1'b0;
      r_noinst <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (prev_valid) pc_o <= pc;
        S_LOOKUP: begin
          if (w_hit) inst_o <= w_hit_word;
          r_cnt    <= '0;
          // After a same-cycle flush every way is invalid, so way 0 is the victim.
          r_vway   <= flush_i ? 1'b0 : w_victim;
          r_noinst <= 1'b0;
        end
        S_FILL: begin
          if (flush_i) r_noinst <= 1'b1;
          if (w_beat) begin
            if (r_cnt == w_off) inst_o <= ifu_rdata;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Refill buffer and line install; the last beat goes straight from the bus into the array.
  always_ff @(posedge clk) begin
    if (w_beat) r_buf[r_cnt] <= ifu_rdata;
    if (w_install) begin
      for (int k = 0; k < LINE_WORDS; k++)
        r_data[r_vway][w_idx][k] <= (k == LINE_WORDS - 1) ? ifu_rdata : r_buf[k];
      r_tag[r_vway][w_idx] <= w_tag;
    end
  end

  // Valid and LRU bits: cleared by reset or flush, set by installs, LRU touched by hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      r_lru <= '0;
    end else if (flush_i) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      r_lru <= '0;
    end else begin
      if ((r_state == S_LOOKUP) && w_hit) r_lru[w_idx] <= w_hit_way;
      if (w_install) begin
        r_valid[r_vway][w_idx] <= 1'b1;
        r_lru[w_idx]           <= r_vway;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_ifu_l1i.sv
// Testbench for ysyx_ifu_l1i: random-latency bus memory plus a timestamp-LRU cache model.
// Latency: checks hit (2 cycles after accept) and miss (1 cycle after last beat) timing.
// Backpressure: holds next_ready low and checks the delivered result stays put.
`timescale 1ns/1ps
module tb_ysyx_ifu_l1i;
  localparam int NS = 16;

  logic        clk = 1'b0, rst = 1'b0;
  logic        prev_valid = 1'b0, next_ready = 1'b0, ifu_rvalid = 1'b0, flush_i = 1'b0;
  logic [31:0] pc = '0, ifu_rdata = '0;
  logic        ready_o, valid_o, ifu_arvalid_o;
  logic [31:0] inst_o, pc_o, ifu_araddr_o;

  int n_pass = 0, n_chk = 0;
  int cyc = 0, last_rv_cyc = 0, ar_cycles = 0, stab_err = 0;
  logic [31:0] rd_q[$];

  logic [31:0] m_line [NS][2];
  bit          m_vld  [NS][2];
  int          m_use  [NS][2];
  int          m_t = 0;

  ysyx_ifu_l1i #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(16), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .prev_valid(prev_valid), .pc(pc), .ready_o(ready_o),
    .valid_o(valid_o), .next_ready(next_ready), .inst_o(inst_o), .pc_o(pc_o),
    .ifu_araddr_o(ifu_araddr_o), .ifu_arvalid_o(ifu_arvalid_o), .ifu_rdata(ifu_rdata),
    .ifu_rvalid(ifu_rvalid), .flush_i(flush_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] memv(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE5EED;
  endfunction

  // Bus memory: one outstanding read, 0..2 cycle random latency, stray rvalid pulses when idle.
  initial begin : bus
    int lat; bit prev_ar; bit prev_rv; logic [31:0] prev_addr;
    lat = 0; prev_ar = 0; prev_rv = 0; prev_addr = '0;
    forever begin
      @(posedge clk); #1;
      ifu_rvalid = 1'b0;
      if (rst) begin
        lat = 0; prev_ar = 0; prev_rv = 0;
      end else if (ifu_arvalid_o) begin
        ar_cycles++;
        if (prev_ar && !prev_rv && ifu_araddr_o !== prev_addr) stab_err++;
        prev_addr = ifu_araddr_o; prev_ar = 1;
        if (lat == 0) begin
          ifu_rvalid = 1'b1; ifu_rdata = memv(ifu_araddr_o);
          rd_q.push_back(ifu_araddr_o); last_rv_cyc = cyc;
          lat = $urandom_range(0, 2); prev_rv = 1;
        end else begin
          lat--; prev_rv = 0;
        end
      end else begin
        prev_ar = 0; prev_rv = 0;
        if ($urandom_range(0, 3) == 0) begin ifu_rvalid = 1'b1; ifu_rdata = $urandom; end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic model_flush();
    for (int s = 0; s < NS; s++) for (int w = 0; w < 2; w++) m_vld[s][w] = 0;
  endtask

  // Reference: per-set list of two lines, LRU by last-use timestamp, empty slot filled first.
  task automatic model_access(input logic [31:0] a, output bit hit);
    logic [31:0] ln; int s; int v;
    ln = a & ~32'hF; s = int'((a >> 4) & 32'hF); m_t++; hit = 0; v = 0;
    for (int w = 0; w < 2; w++)
      if (m_vld[s][w] && m_line[s][w] == ln) begin hit = 1; m_use[s][w] = m_t; end
    if (!hit) begin
      if (!m_vld[s][0]) v = 0;
      else if (!m_vld[s][1]) v = 1;
      else v = (m_use[s][0] < m_use[s][1]) ? 0 : 1;
      m_line[s][v] = ln; m_vld[s][v] = 1; m_use[s][v] = m_t;
    end
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1; @(negedge clk); flush_i = 1'b0;
  endtask

  // Issues one fetch starting at a negedge; returns at a negedge.
  task automatic fetch(input logic [31:0] a, input bit consume, output bit done, output int lat,
                       output int gap, output int arc, output logic [31:0] o_inst, output logic [31:0] o_pc);
    int n;
    rd_q.delete(); ar_cycles = 0; done = 0; gap = 0;
    n = 0;
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    prev_valid = 1'b1; pc = a;
    @(negedge clk); prev_valid = 1'b0; pc = $urandom;
    lat = 1;
    while (!valid_o && lat < 200) begin @(negedge clk); lat++; end
    done = valid_o; gap = cyc - last_rv_cyc; arc = ar_cycles;
    o_inst = inst_o; o_pc = pc_o;
    if (consume) begin
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
      next_ready = 1'b1; @(negedge clk); next_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (valid_o !== 1'b0)       $display("FAIL reset_valid got=%0h exp=0", valid_o); else n_pass++;
    n_chk++; if (ready_o !== 1'b1)       $display("FAIL reset_ready got=%0h exp=1", ready_o); else n_pass++;
    n_chk++; if (ifu_arvalid_o !== 1'b0) $display("FAIL reset_arvalid got=%0h exp=0", ifu_arvalid_o); else n_pass++;
    n_chk++; if (ifu_araddr_o !== 32'h0) $display("FAIL reset_araddr got=%0h exp=0", ifu_araddr_o); else n_pass++;
    n_chk++; if (inst_o !== 32'h0)       $display("FAIL reset_inst got=%0h exp=0", inst_o); else n_pass++;
    n_chk++; if (pc_o !== 32'h0)         $display("FAIL reset_pc got=%0h exp=0", pc_o); else n_pass++;
    rst = 1'b0; model_flush();
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    bit d, h; int lat, gap, arc; logic [31:0] oi, op, got;
    model_access(32'h80000008, h);
    fetch(32'h80000008, 1, d, lat, gap, arc, oi, op);
    n_chk++; if (d !== 1'b1) $display("FAIL cold_done got=%0b exp=1", d); else n_pass++;
    n_chk++; if (rd_q.size() != 4) $display("FAIL cold_nreads got=%0d exp=4", rd_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      got = (k < rd_q.size()) ? rd_q[k] : 32'hDEADBEEF;
      n_chk++; if (got !== 32'h80000000 + 32'(4 * k))
        $display("FAIL cold_addr%0d got=%0h exp=%0h", k, got, 32'h80000000 + 32'(4 * k)); else n_pass++;
    end
    n_chk++; if (oi !== memv(32'h80000008)) $display("FAIL cold_inst got=%0h exp=%0h", oi, memv(32'h80000008)); else n_pass++;
    n_chk++; if (op !== 32'h80000008) $display("FAIL cold_pc got=%0h exp=80000008", op); else n_pass++;
    n_chk++; if (gap != 1) $display("FAIL cold_latency got=%0d exp=1 cycles after last rvalid", gap); else n_pass++;
  endtask

  task automatic test_hit();
    bit d, h; int lat, gap, arc; logic [31:0] oi, op;
    model_access(32'h8000000C, h);
    fetch(32'h8000000C, 1, d, lat, gap, arc, oi, op);
    n_chk++; if (arc != 0) $display("FAIL hit_arvalid got=%0d exp=0 cycles", arc); else n_pass++;
    n_chk++; if (lat != 2) $display("FAIL hit_latency got=%0d exp=2", lat); else n_pass++;
    n_chk++; if (oi !== memv(32'h8000000C)) $display("FAIL hit_inst got=%0h exp=%0h", oi, memv(32'h8000000C)); else n_pass++;
  endtask

  task automatic test_flush();
    bit d, d2, h; int lat, gap, arc; logic [31:0] oi, op;
    // Flush while idle, then the cached line must miss.
    pulse_flush(); model_flush();
    model_access(32'h80000000, h);
    fetch(32'h80000000, 1, d, lat, gap, arc, oi, op);
    n_chk++; if (rd_q.size() != 4) $display("FAIL flush_idle_nreads got=%0d exp=4", rd_q.size()); else n_pass++;
    // Flush during refill: instruction still delivered, line not kept.
    pulse_flush(); model_flush();
    fork
      fetch(32'h80000044, 1, d, lat, gap, arc, oi, op);
      begin
        int n; n = 0;
        @(negedge clk);
        while (rd_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
        pulse_flush();
      end
    join
    model_flush();
    n_chk++; if (d !== 1'b1 || oi !== memv(32'h80000044))
      $display("FAIL flush_fill_inst got=%0h exp=%0h", oi, memv(32'h80000044)); else n_pass++;
    model_access(32'h80000044, h);
    fetch(32'h80000044, 1, d, lat, gap, arc, oi, op);
    n_chk++; if (rd_q.size() != 4) $display("FAIL flush_fill_noinstall got=%0d exp=4 reads", rd_q.size()); else n_pass++;
    // Flush during lookup forces a miss; the refilled line is then usable.
    fork
      fetch(32'h80000044, 1, d2, lat, gap, arc, oi, op);
      begin @(negedge clk); pulse_flush(); end
    join
    model_flush(); model_access(32'h80000044, h);
    n_chk++; if (rd_q.size() != 4 || oi !== memv(32'h80000044))
      $display("FAIL flush_lookup got=%0d reads inst=%0h exp=4 reads inst=%0h", rd_q.size(), oi, memv(32'h80000044)); else n_pass++;
    model_access(32'h80000048, h);
    fetch(32'h80000048, 1, d, lat, gap, arc, oi, op);
    n_chk++; if (rd_q.size() != 0 || lat != 2) $display("FAIL flush_lookup_rehit got=%0d reads lat=%0d exp=0 reads lat=2", rd_q.size(), lat); else n_pass++;
  endtask

  task automatic test_lru();
    logic [31:0] seq [6];
    int exp_n [6];
    bit d, h; int lat, gap, arc; logic [31:0] oi, op;
    seq   = '{32'h80000000, 32'h80000100, 32'h80000000, 32'h80000200, 32'h80000000, 32'h80000100};
    exp_n = '{4, 4, 0, 4, 0, 4};
    pulse_flush(); model_flush();
    for (int i = 0; i < 6; i++) begin
      model_access(seq[i], h);
      fetch(seq[i], 1, d, lat, gap, arc, oi, op);
      n_chk++; if (rd_q.size() != exp_n[i])
        $display("FAIL lru_step%0d pc=%0h got=%0d reads exp=%0d", i, seq[i], rd_q.size(), exp_n[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit d, h; int lat, gap, arc; logic [31:0] oi, op;
    model_access(32'h80000008, h);
    fetch(32'h80000008, 0, d, lat, gap, arc, oi, op);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++; if (valid_o !== 1'b1) $display("FAIL bp_valid%0d got=%0b exp=1", i, valid_o); else n_pass++;
      n_chk++; if (ready_o !== 1'b0) $display("FAIL bp_ready%0d got=%0b exp=0", i, ready_o); else n_pass++;
      n_chk++; if (inst_o !== memv(32'h80000008)) $display("FAIL bp_inst%0d got=%0h exp=%0h", i, inst_o, memv(32'h80000008)); else n_pass++;
      n_chk++; if (pc_o !== 32'h80000008) $display("FAIL bp_pc%0d got=%0h exp=80000008", i, pc_o); else n_pass++;
    end
    next_ready = 1'b1; @(negedge clk); next_ready = 1'b0;
    n_chk++; if (valid_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL bp_release got valid=%0b ready=%0b exp valid=0 ready=1", valid_o, ready_o); else n_pass++;
  endtask

  task automatic test_reset_midfill();
    bit d, h; int n, lat, gap, arc; logic [31:0] oi, op;
    rd_q.delete();
    prev_valid = 1'b1; pc = 32'h80000F34;
    @(negedge clk); prev_valid = 1'b0;
    n = 0;
    while (rd_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    n_chk++; if (rd_q.size() != 2) $display("FAIL midfill_beats got=%0d exp=2", rd_q.size()); else n_pass++;
    rst = 1'b1; #1;
    n_chk++; if (ifu_arvalid_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL midfill_async got arvalid=%0b ready=%0b exp arvalid=0 ready=1", ifu_arvalid_o, ready_o); else n_pass++;
    @(negedge clk); rst = 1'b0; model_flush();
    @(negedge clk);
    model_access(32'h80000F34, h);
    fetch(32'h80000F34, 1, d, lat, gap, arc, oi, op);
    n_chk++; if (rd_q.size() != 4 || oi !== memv(32'h80000F34))
      $display("FAIL midfill_refetch got=%0d reads inst=%0h exp=4 reads inst=%0h", rd_q.size(), oi, memv(32'h80000F34)); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] tg [3];
    logic [31:0] a, got;
    bit d, h, lat_ok; int lat, gap, arc, en;
    logic [31:0] oi, op;
    tg = '{32'h80000000, 32'h80000400, 32'h80000800};
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin pulse_flush(); model_flush(); end
      a = tg[$urandom_range(0, 2)] | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      model_access(a, h);
      en = h ? 0 : 4;
      fetch(a, 1, d, lat, gap, arc, oi, op);
      n_chk++; if (rd_q.size() != en) $display("FAIL rnd%0d_nreads pc=%0h got=%0d exp=%0d", i, a, rd_q.size(), en); else n_pass++;
      n_chk++; if (d !== 1'b1 || oi !== memv(a)) $display("FAIL rnd%0d_inst pc=%0h got=%0h exp=%0h", i, a, oi, memv(a)); else n_pass++;
      n_chk++; if (op !== a) $display("FAIL rnd%0d_pc got=%0h exp=%0h", i, op, a); else n_pass++;
      lat_ok = h ? (lat == 2) : (gap == 1);
      n_chk++; if (!lat_ok) $display("FAIL rnd%0d_latency hit=%0b got lat=%0d gap=%0d", i, h, lat, gap); else n_pass++;
      if (!h) begin
        got = (rd_q.size() > 0) ? rd_q[0] : 32'hDEADBEEF;
        n_chk++; if (got !== (a & ~32'hF)) $display("FAIL rnd%0d_base got=%0h exp=%0h", i, got, a & ~32'hF); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_flush();
    test_lru();
    test_backpressure();
    test_reset_midfill();
    test_random();
    n_chk++; if (stab_err != 0) $display("FAIL araddr_stable got=%0d changes exp=0", stab_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
